// File: rtl/alu_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl_pkg
// Description : ALU control codes, sequencer state encoding and the
//               per-operation hold-latency selector for alu_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_ctrl_pkg;

  // ALU control codes; 14 and 15 are undefined and make the ALU output zero
  localparam logic [3:0] CTRL_ALU_ADD = 4'd0;
  localparam logic [3:0] CTRL_ALU_SUB = 4'd1;
  localparam logic [3:0] CTRL_ALU_AND = 4'd2;
  localparam logic [3:0] CTRL_ALU_OR  = 4'd3;
  localparam logic [3:0] CTRL_ALU_XOR = 4'd4;
  localparam logic [3:0] CTRL_ALU_NOT = 4'd5;
  localparam logic [3:0] CTRL_ALU_NEG = 4'd6;
  localparam logic [3:0] CTRL_ALU_SHL = 4'd7;
  localparam logic [3:0] CTRL_ALU_SHR = 4'd8;
  localparam logic [3:0] CTRL_ALU_SAR = 4'd9;
  localparam logic [3:0] CTRL_ALU_ROL = 4'd10;
  localparam logic [3:0] CTRL_ALU_ROR = 4'd11;
  localparam logic [3:0] CTRL_ALU_MUL = 4'd12;
  localparam logic [3:0] CTRL_ALU_DIV = 4'd13;

  // Sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_HOLD    = 2'd1,
    SEQ_CAPTURE = 2'd2
  } seq_state_t;

  // Number of cycles the ALU inputs must stay stable for a given control code
  function automatic int unsigned seq_lat_sel(
    input logic [3:0]  ctrl,
    input int unsigned short_lat,
    input int unsigned mul_lat,
    input int unsigned div_lat
  );
    if (ctrl == CTRL_ALU_MUL)      return mul_lat;
    else if (ctrl == CTRL_ALU_DIV) return div_lat;
    else                           return short_lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl_if
// Description : Request/result bundle between a requester (master) and the
//               ALU sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_ctrl_if;

  logic        iValid;
  logic        oReady;
  logic [3:0]  iCtrl;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iAbort;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oHi;
  logic [31:0] oLo;
  logic        oZero;
  logic        oNeg;

  modport master (
    output iValid, iCtrl, iA, iB, iAbort,
    input  oReady, oBusy, oDone, oHi, oLo, oZero, oNeg
  );

  modport slave (
    input  iValid, iCtrl, iA, iB, iAbort,
    output oReady, oBusy, oDone, oHi, oLo, oZero, oNeg
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl_alu
// Description : Combinational 32-bit ALU with 64-bit result (hi/lo) and
//               zero/negative flags. MUL and DIV are long paths that the
//               sequencer treats as multicycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl_alu
  import alu_seq_ctrl_pkg::*;
(
  input  logic [3:0]  iCtrl,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic [31:0] oC_hi,
  output logic [31:0] oC_lo,
  output logic        oZero,
  output logic        oNeg
);

  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [63:0] w_prod;
  logic [4:0]         w_sh;
  logic [5:0]         w_shc;
  logic [31:0]        w_hi;
  logic [31:0]        w_lo;

  assign w_sa   = $signed(iA);
  assign w_sb   = $signed(iB);
  assign w_prod = 64'(w_sa) * 64'(w_sb);
  assign w_sh   = iB[4:0];
  // Complementary rotate amount; a shift by 32 yields zero, so rotate-by-0 works
  assign w_shc  = 6'd32 - {1'b0, w_sh};

  // Operation select; single-width operations leave the high word at zero
  always_comb begin
    w_hi = '0;
    w_lo = '0;
    case (iCtrl)
      CTRL_ALU_ADD: w_lo = iA + iB;
      CTRL_ALU_SUB: w_lo = iA - iB;
      CTRL_ALU_AND: w_lo = iA & iB;
      CTRL_ALU_OR:  w_lo = iA | iB;
      CTRL_ALU_XOR: w_lo = iA ^ iB;
      CTRL_ALU_NOT: w_lo = ~iA;
      CTRL_ALU_NEG: w_lo = 32'd0 - iA;
      CTRL_ALU_SHL: w_lo = iA << w_sh;
      CTRL_ALU_SHR: w_lo = iA >> w_sh;
      CTRL_ALU_SAR: w_lo = w_sa >>> w_sh;
      CTRL_ALU_ROL: w_lo = (iA << w_sh) | (iA >> w_shc);
      CTRL_ALU_ROR: w_lo = (iA >> w_sh) | (iA << w_shc);
      CTRL_ALU_MUL: begin
        w_hi = w_prod[63:32];
        w_lo = w_prod[31:0];
      end
      CTRL_ALU_DIV: begin
        // Signed truncating division; remainder takes the dividend's sign.
        // Divide-by-zero gives all-ones quotient and the dividend as remainder;
        // the one overflowing case (INT_MIN / -1) wraps to INT_MIN, remainder 0.
        if (iB == 32'd0) begin
          w_lo = '1;
          w_hi = iA;
        end else if (iA == 32'h8000_0000 && iB == 32'hFFFF_FFFF) begin
          w_lo = iA;
          w_hi = '0;
        end else begin
          w_lo = w_sa / w_sb;
          w_hi = w_sa % w_sb;
        end
      end
      default: begin
        w_hi = '0;
        w_lo = '0;
      end
    endcase
  end

  assign oC_hi = w_hi;
  assign oC_lo = w_lo;
  // Zero covers the full 64-bit result; sign comes from the top word in use
  assign oZero = ({w_hi, w_lo} == 64'd0);
  assign oNeg  = (iCtrl == CTRL_ALU_MUL) ? w_hi[31] : w_lo[31];

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Multi-cycle sequencer around the combinational ALU. Latches
//               one request, holds the ALU inputs for a per-class number of
//               cycles, then captures result and flags and pulses oDone.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned SHORT_LAT = 1,
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned DIV_LAT   = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic         iClk,
  input  logic         nRst,
  alu_seq_ctrl_if.slave bus
);

  seq_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_ctrl;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_zero;
  logic               r_neg;

  logic [31:0]        w_c_hi;
  logic [31:0]        w_c_lo;
  logic               w_zero;
  logic               w_neg;
  logic [CNT_W-1:0]   w_lat_m1;

  // Counter preload for the incoming request: hold cycles minus one
  assign w_lat_m1 = CNT_W'(seq_lat_sel(bus.iCtrl, SHORT_LAT, MUL_LAT, DIV_LAT) - 1);

  // The ALU only ever sees the latched request, never the live bus
  alu_seq_ctrl_alu u_alu (
    .iCtrl (r_ctrl),
    .iA    (r_a),
    .iB    (r_b),
    .oC_hi (w_c_hi),
    .oC_lo (w_c_lo),
    .oZero (w_zero),
    .oNeg  (w_neg)
  );

  // Sequencer FSM with registered handshake, done pulse and result registers
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
      r_ctrl  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_zero  <= 1'b1;
      r_neg   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          // Abort has nothing to cancel here and does not block acceptance
          if (bus.iValid) begin
            r_ctrl  <= bus.iCtrl;
            r_a     <= bus.iA;
            r_b     <= bus.iB;
            r_cnt   <= w_lat_m1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SEQ_HOLD;
          end
        end
        SEQ_HOLD: begin
          // Abort beats the final hold cycle so a cancelled op never writes
          if (bus.iAbort) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= SEQ_IDLE;
          end else if (r_cnt == '0) begin
            r_hi    <= w_c_hi;
            r_lo    <= w_c_lo;
            r_zero  <= w_zero;
            r_neg   <= w_neg;
            r_done  <= 1'b1;
            r_state <= SEQ_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        SEQ_CAPTURE: begin
          // Done cycle: results already written, leave ready low for one more
          // cycle so no new request is taken while oDone is visible
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= SEQ_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign bus.oReady = r_ready;
  assign bus.oBusy  = r_busy;
  assign bus.oDone  = r_done;
  assign bus.oHi    = r_hi;
  assign bus.oLo    = r_lo;
  assign bus.oZero  = r_zero;
  assign bus.oNeg   = r_neg;

endmodule
`default_nettype wire
